// File: rtl/packed_struct_assembler.sv
// Field-serial assembler for a 15-bit packed record {e0:1, e1:2, e2:4, e3:8}.
// Fields land directly in the output register; the finished word is held until downstream accepts it.
module packed_struct_assembler #(
    parameter bit ASCENDING = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      out_data,
    output logic             dup_err,
    output logic [CNT_W-1:0] rec_count
);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_mask;
    logic             r_out_valid;
    logic [14:0]      r_out_data;
    logic             r_dup_err;
    logic [CNT_W-1:0] r_rec_count;

    logic             w_write;
    logic [3:0]       w_sel_onehot;
    logic [3:0]       w_mask_next;
    logic [1:0]       w_e1;
    logic [3:0]       w_e2;
    logic [7:0]       w_e3;

    // Ascending member ranges put in_data[k] at element [k], i.e. bit W-1-k of the slot.
    genvar gi;
    generate
        if (ASCENDING) begin : g_asc
            for (gi = 0; gi < 2; gi++) begin : g_e1
                assign w_e1[1-gi] = in_data[gi];
            end
            for (gi = 0; gi < 4; gi++) begin : g_e2
                assign w_e2[3-gi] = in_data[gi];
            end
            for (gi = 0; gi < 8; gi++) begin : g_e3
                assign w_e3[7-gi] = in_data[gi];
            end
        end else begin : g_dsc
            assign w_e1 = in_data[1:0];
            assign w_e2 = in_data[3:0];
            assign w_e3 = in_data[7:0];
        end
    endgenerate

    assign w_write      = in_valid && (r_state == S_COLLECT);
    assign w_sel_onehot = 4'b0001 << in_sel;
    assign w_mask_next  = r_mask | w_sel_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_COLLECT;
            r_mask      <= 4'b0000;
            r_out_valid <= 1'b0;
            r_out_data  <= 15'd0;
            r_dup_err   <= 1'b0;
            r_rec_count <= '0;
        end else begin
            r_dup_err <= w_write && |(r_mask & w_sel_onehot);
            case (r_state)
                S_COLLECT: begin
                    if (w_write) begin
                        r_mask <= w_mask_next;
                        case (in_sel)
                            2'd0:    r_out_data[14]    <= in_data[0];
                            2'd1:    r_out_data[13:12] <= w_e1;
                            2'd2:    r_out_data[11:8]  <= w_e2;
                            default: r_out_data[7:0]   <= w_e3;
                        endcase
                        if (&w_mask_next) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_mask      <= 4'b0000;
                        r_rec_count <= r_rec_count + CNT_W'(1);
                        r_state     <= S_COLLECT;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign in_ready  = (r_state == S_COLLECT);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign dup_err   = r_dup_err;
    assign rec_count = r_rec_count;

endmodule

// File: tb/tb_packed_struct_assembler.sv
// Directed bench: descending and ascending instances share one stimulus stream.
module tb_packed_struct_assembler;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        dsc_in_ready, asc_in_ready;
    logic        dsc_out_valid, asc_out_valid;
    logic [14:0] dsc_out_data, asc_out_data;
    logic        dsc_dup_err, asc_dup_err;
    logic [7:0]  dsc_rec_count, asc_rec_count;

    int n_vec = 0;
    int n_err = 0;

    packed_struct_assembler #(.ASCENDING(1'b0), .CNT_W(8)) u_dsc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(dsc_in_ready),
        .in_sel(in_sel), .in_data(in_data),
        .out_valid(dsc_out_valid), .out_ready(out_ready),
        .out_data(dsc_out_data), .dup_err(dsc_dup_err),
        .rec_count(dsc_rec_count)
    );

    packed_struct_assembler #(.ASCENDING(1'b1), .CNT_W(8)) u_asc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(asc_in_ready),
        .in_sel(in_sel), .in_data(in_data),
        .out_valid(asc_out_valid), .out_ready(out_ready),
        .out_data(asc_out_data), .dup_err(asc_dup_err),
        .rec_count(asc_rec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        step();
        in_valid = 1'b0;
    endtask

    task automatic emit_record(input logic [7:0] d3, output logic ov, output logic ov_after);
        out_ready = 1'b1;
        wr(2'd0, 8'd0);
        wr(2'd1, 8'd0);
        wr(2'd2, 8'd0);
        wr(2'd3, d3);
        ov = dsc_out_valid & asc_out_valid;
        step();
        ov_after = dsc_out_valid | asc_out_valid;
    endtask

    initial begin
        logic ov, ov_after;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'd0;
        out_ready = 1'b0;

        // Reset state
        step();
        chk("rst out_valid", {dsc_out_valid, asc_out_valid}, 2'b00);
        chk("rst out_data",  {dsc_out_data, asc_out_data}, 30'd0);
        chk("rst in_ready",  {dsc_in_ready, asc_in_ready}, 2'b11);
        chk("rst dup_err",   {dsc_dup_err, asc_dup_err}, 2'b00);
        chk("rst rec_count", {dsc_rec_count, asc_rec_count}, 16'd0);
        rst_n = 1'b1;
        step();

        // Record 1: e3=0x5C, e0=1, e2=0xA, e1=2
        wr(2'd3, 8'h5C);
        wr(2'd0, 8'h01);
        wr(2'd2, 8'h0A);
        chk("partial out_valid", {dsc_out_valid, asc_out_valid}, 2'b00);
        wr(2'd1, 8'h02);
        chk("rec1 out_valid", {dsc_out_valid, asc_out_valid}, 2'b11);
        chk("rec1 in_ready",  {dsc_in_ready, asc_in_ready}, 2'b00);
        chk("rec1 dsc data",  dsc_out_data, 15'h6A5C);
        chk("rec1 asc data",  asc_out_data, 15'h553A);

        // Backpressure with a persistent write request
        in_valid = 1'b1;
        in_sel   = 2'd3;
        in_data  = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp dsc data", dsc_out_data, 15'h6A5C);
            chk("bp asc data", asc_out_data, 15'h553A);
            chk("bp in_ready", {dsc_in_ready, asc_in_ready, dsc_out_valid, asc_out_valid}, 4'b0011);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("accept out_valid", {dsc_out_valid, asc_out_valid}, 2'b00);
        chk("accept in_ready",  {dsc_in_ready, asc_in_ready}, 2'b11);
        chk("accept rec_count", {dsc_rec_count, asc_rec_count}, {8'd1, 8'd1});
        chk("accept held data", dsc_out_data, 15'h6A5C);

        // Duplicate e1 and upper-bit truncation
        wr(2'd1, 8'hFF);
        chk("dup first write", {dsc_dup_err, asc_dup_err}, 2'b00);
        wr(2'd1, 8'h01);
        chk("dup pulse", {dsc_dup_err, asc_dup_err}, 2'b11);
        step();
        chk("dup one cycle", {dsc_dup_err, asc_dup_err}, 2'b00);
        wr(2'd0, 8'hFE);
        wr(2'd2, 8'hF3);
        wr(2'd3, 8'h81);
        chk("rec2 out_valid", {dsc_out_valid, asc_out_valid}, 2'b11);
        chk("rec2 dsc data",  dsc_out_data, 15'h1381);
        chk("rec2 asc data",  asc_out_data, 15'h2C81);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rec2 rec_count", {dsc_rec_count, asc_rec_count}, {8'd2, 8'd2});

        // Back-to-back duplicates
        wr(2'd3, 8'h01);
        chk("b2b none", dsc_dup_err, 1'b0);
        wr(2'd3, 8'h02);
        chk("b2b pulse1", {dsc_dup_err, asc_dup_err}, 2'b11);
        wr(2'd3, 8'h03);
        chk("b2b pulse2", {dsc_dup_err, asc_dup_err}, 2'b11);
        wr(2'd0, 8'h01);
        chk("b2b end", {dsc_dup_err, asc_dup_err}, 2'b00);

        // Asynchronous reset mid-collection
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_data",  {dsc_out_data, asc_out_data}, 30'd0);
        chk("arst out_valid", {dsc_out_valid, asc_out_valid}, 2'b00);
        chk("arst rec_count", {dsc_rec_count, asc_rec_count}, 16'd0);
        step();
        rst_n = 1'b1;
        step();
        wr(2'd1, 8'h03);
        wr(2'd2, 8'h05);
        wr(2'd3, 8'hA5);
        chk("post-rst mask clear", {dsc_out_valid, asc_out_valid}, 2'b00);
        wr(2'd0, 8'h00);
        chk("rec3 out_valid", {dsc_out_valid, asc_out_valid}, 2'b11);
        chk("rec3 dsc data",  dsc_out_data, 15'h35A5);
        chk("rec3 asc data",  asc_out_data, 15'h3AA5);
        out_ready = 1'b1;
        step();
        chk("rec3 rec_count", {dsc_rec_count, asc_rec_count}, {8'd1, 8'd1});

        // Counter wrap
        for (int i = 0; i < 254; i++) begin
            emit_record(8'(i), ov, ov_after);
            chk("wrap out_valid", {ov, ov_after}, 2'b10);
        end
        chk("wrap 255", {dsc_rec_count, asc_rec_count}, {8'd255, 8'd255});
        emit_record(8'h77, ov, ov_after);
        chk("wrap last out_valid", {ov, ov_after}, 2'b10);
        chk("wrap 0", {dsc_rec_count, asc_rec_count}, 16'd0);
        chk("wrap dsc data", dsc_out_data, 15'h0077);
        chk("wrap asc data", asc_out_data, 15'h00EE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
